decoder_scan: RTL and testbench
===============================

# decoder_scan

Registered, parametrised N-to-2^N one-hot decoder with enable and an auto-scan mode. Direct mode decodes `In` every cycle, with the output registered. Scan mode steps the active output through all 2^N positions, holding each one for `DWELL` cycles. It drives multiplexed display digit/row selects and any other time-sliced one-hot select in the lab designs. It is the sequential successor of the fixed 3-to-8 combinational decoder.

## Interface
- `N`, default 3: select width. Legal range 1..6. `Out` width is 2^N.
- `DWELL`, default 4: cycles each position is held in scan mode. Legal range 1..65535.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `E`  in  1  enable. When 0, `Out` is all-zero and scanning pauses.
- `Mode`  in  1  0 = direct decode of `In`; 1 = auto-scan.
- `Load`  in  1  scan mode only: load `In` into the scan index.
- `In`  in  N  select value (direct mode) or load value (scan mode).
- `Dir`  in  1  scan direction, 0 = up, 1 = down. Present only with `DECODER_SCAN_DIR_EN`.
- `Out`  out  2^N  registered one-hot output, bit `Idx` set.
- `Idx`  out  N  registered index currently driven on `Out`.
- `Valid`  out  1  registered; 1 when `Out` is non-zero.
- `Wrap`  out  1  one-cycle pulse on scan wrap-around.

## Operation
- Internal state:
  - scan index `sidx` (N bits).
  - dwell counter `dcnt`, width ceil(log2(DWELL)), minimum 1.
- Reset (`rst_n`=0 at a rising edge): `Out`=0, `Idx`=0, `Valid`=0, `Wrap`=0, `sidx`=0, `dcnt`=0. Reset overrides all inputs.
- `E`=0:
  - Next cycle: `Out`=0, `Valid`=0, `Wrap`=0.
  - `Idx`, `sidx` hold their values; `dcnt` clears to 0.
- Direct mode (`E`=1, `Mode`=0):
  - `Idx`<=`In`, `Out`<=1<<`In`, `Valid`<=1.
  - `sidx` and `dcnt` hold. `Load` is ignored. `Wrap`=0.
- Scan mode (`E`=1, `Mode`=1), in priority order:
  1. `Load`=1: `sidx`<=`In`, `dcnt`<=0. `Out`/`Idx` show `In` on the next cycle.
  2. Else, if `dcnt`==`DWELL`-1: `dcnt`<=0 and `sidx` steps to the next index, with modulo-2^N wrap.
  3. Else: `dcnt`<=`dcnt`+1 and `sidx` holds.
  - `Out`/`Idx` always reflect the updated `sidx`, registered one cycle after the deciding edge.
- Wrap:
  - Up direction: step from 2^N-1 to 0.
  - Down direction: step from 0 to 2^N-1.
  - `Wrap`=1 for exactly the cycle in which `Out` first shows the wrapped index. A `Load` to 0 does not assert `Wrap`.
- Mode change:
  - Entering scan mode: scanning resumes from the held `sidx` with `dcnt`=0. It does not resume from the last direct `In`.
  - Leaving scan mode: `sidx` is retained.
- `DWELL`=1: the index advances every cycle.
- `Out` is one-hot or all-zero in every cycle; it never has more than one bit set.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Direct-mode latency: `In` sampled at edge k appears on `Out` after edge k.
- Scan period: each index is visible for exactly `DWELL` cycles. A full cycle takes `DWELL`*2^N cycles.
- Simultaneous events:
  - `Load` and a dwell expiry in the same cycle: `Load` wins, no step, no `Wrap`.
  - `E`=0 outranks `Load`: a `Load` with `E`=0 is discarded.
- Reset mid-scan: the next cycle shows `Out`=0, `Valid`=0. After release, scanning starts at index 0 with a full `DWELL` hold, provided `E`=1 and `Mode`=1.

## Configuration
- `DECODER_SCAN_DIR_EN` defined:
  - The `Dir` port exists and is sampled at every step.
  - `Dir`=1 decrements `sidx`, wrapping 0 to 2^N-1 with a `Wrap` pulse.
  - A change of `Dir` takes effect at the next step and does not reset `dcnt`.
- `DECODER_SCAN_DIR_EN` undefined: no `Dir` port; scanning is up-only.

## Test plan
- Reset/enable (N=3): hold `rst_n`=0 for 2 cycles, then release with `E`=0 → `Out`=8'h00, `Idx`=0, `Valid`=0, `Wrap`=0 throughout.
- Direct sweep (N=3, `E`=1, `Mode`=0): drive `In`=0..7, one value per cycle → `Out`=8'h01, 02, 04 … 80, each one cycle after its `In`, with `Valid`=1.
- Scan with wrap (N=2, `DWELL`=3): run scan mode for 14 cycles → `Idx` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0 → `Wrap`=1 only on the first cycle showing index 0 after 3.
- Load priority (N=3, `DWELL`=4): assert `Load` with `In`=5 on the dwell-expiry cycle of index 2 → next `Out`=8'h20, held 4 cycles, then 8'h40; no `Wrap`.
- Pause and reset (N=3, `DWELL`=2):
  - Drop `E` while at index 6 for 3 cycles → `Out`=0 during the pause. Restore `E` → index 6 is held 2 full cycles, then 7.
  - Pull `rst_n` low while at index 7 → next `Out`=0. After release → index 0.
- Down scan (`DECODER_SCAN_DIR_EN`, N=2, `DWELL`=1, `Dir`=1, starting from `Load` `In`=1) → `Idx` 1,0,3,2 → `Wrap` on the cycle showing index 3.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, direct decode and auto-scan modes.
// Latency: one cycle from any sampled input to o_out/o_idx/o_valid/o_wrap (all registered).
// Backpressure: none; the block accepts new inputs every cycle. i_e=0 blanks the output and pauses scanning.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_e      enable; 0 blanks o_out and pauses the scan
//   i_mode   0 = direct decode of i_in, 1 = auto-scan
//   i_load   scan mode only: load i_in into the scan index
//   i_in     select value (direct) or load value (scan)
//   i_dir    scan direction, 0 = up, 1 = down (only with DECODER_SCAN_DIR_EN)
//   o_out    one-hot output, bit o_idx set (or all-zero)
//   o_idx    index currently driven on o_out
//   o_valid  1 when o_out is non-zero
//   o_wrap   one-cycle pulse when o_out first shows a wrapped scan index
//
// Optional feature: define DECODER_SCAN_DIR_EN to add i_dir (down-scan support).
// Without it the scan runs up only.

module decoder_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_e,
    input  logic              i_mode,
    input  logic              i_load,
    input  logic [N-1:0]      i_in,
`ifdef DECODER_SCAN_DIR_EN
    input  logic              i_dir,
`endif
    output logic [(1<<N)-1:0] o_out,
    output logic [N-1:0]      o_idx,
    output logic              o_valid,
    output logic              o_wrap
);

    localparam int            OW        = 1 << N;
    localparam int            DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_MAX   = {N{1'b1}};

    logic [N-1:0]  r_sidx;
    logic [DW-1:0] r_dcnt;
    // Set while the previous edge was an enabled scan-mode edge. The first scan
    // edge after reset, a pause or direct mode only re-arrives at r_sidx, so the
    // held index gets its full dwell instead of being shortened by one cycle.
    logic          r_scan_q;

    logic          w_dir_dn;
    logic [N-1:0]  w_step_idx;
    logic          w_step_wrap;
    logic [N-1:0]  w_sidx_nxt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_wrap_nxt;

`ifdef DECODER_SCAN_DIR_EN
    assign w_dir_dn = i_dir;
`else
    assign w_dir_dn = 1'b0;
`endif

    // Modulo-2^N stepping falls out of the N-bit arithmetic.
    assign w_step_idx  = w_dir_dn ? (r_sidx - N'(1)) : (r_sidx + N'(1));
    assign w_step_wrap = w_dir_dn ? (r_sidx == '0) : (r_sidx == IDX_MAX);

    // Next scan state, used only on enabled scan-mode edges.
    always_comb begin
        w_sidx_nxt = r_sidx;
        w_dcnt_nxt = r_dcnt;
        w_wrap_nxt = 1'b0;
        if (i_load) begin
            // Load outranks a dwell expiry; a load never signals a wrap.
            w_sidx_nxt = i_in;
            w_dcnt_nxt = '0;
        end else if (!r_scan_q) begin
            w_dcnt_nxt = '0;
        end else if (r_dcnt == DCNT_LAST) begin
            w_sidx_nxt = w_step_idx;
            w_dcnt_nxt = '0;
            w_wrap_nxt = w_step_wrap;
        end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sidx   <= '0;
            r_dcnt   <= '0;
            r_scan_q <= 1'b0;
            o_out    <= '0;
            o_idx    <= '0;
            o_valid  <= 1'b0;
            o_wrap   <= 1'b0;
        end else if (!i_e) begin
            // Pause: blank the output, keep o_idx and r_sidx, restart the dwell.
            r_dcnt   <= '0;
            r_scan_q <= 1'b0;
            o_out    <= '0;
            o_valid  <= 1'b0;
            o_wrap   <= 1'b0;
        end else if (!i_mode) begin
            // Direct decode; scan state is left untouched for a later return.
            r_scan_q <= 1'b0;
            o_idx    <= i_in;
            o_out    <= OW'(1) << i_in;
            o_valid  <= 1'b1;
            o_wrap   <= 1'b0;
        end else begin
            r_sidx   <= w_sidx_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_scan_q <= 1'b1;
            o_idx    <= w_sidx_nxt;
            o_out    <= OW'(1) << w_sidx_nxt;
            o_valid  <= 1'b1;
            o_wrap   <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: four instances with different N/DWELL share one stimulus.
// Every edge is checked against a position/dwell-time reference model; directed phases
// additionally check the fixed sequences, then a randomized phase exercises everything.

module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       e     = 1'b0;
    logic       mode  = 1'b0;
    logic       load  = 1'b0;
    logic       dir   = 1'b0;
    logic [2:0] din   = 3'd0;

    logic [7:0] d0_out, d2_out;
    logic [3:0] d1_out, d3_out;
    logic [2:0] d0_idx, d2_idx;
    logic [1:0] d1_idx, d3_idx;
    logic [3:0] vld, wrp;

    decoder_scan #(.N(3), .DWELL(4)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_mode(mode), .i_load(load), .i_in(din),
`ifdef DECODER_SCAN_DIR_EN
        .i_dir(dir),
`endif
        .o_out(d0_out), .o_idx(d0_idx), .o_valid(vld[0]), .o_wrap(wrp[0]));

    decoder_scan #(.N(2), .DWELL(3)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_mode(mode), .i_load(load), .i_in(din[1:0]),
`ifdef DECODER_SCAN_DIR_EN
        .i_dir(dir),
`endif
        .o_out(d1_out), .o_idx(d1_idx), .o_valid(vld[1]), .o_wrap(wrp[1]));

    decoder_scan #(.N(3), .DWELL(2)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_mode(mode), .i_load(load), .i_in(din),
`ifdef DECODER_SCAN_DIR_EN
        .i_dir(dir),
`endif
        .o_out(d2_out), .o_idx(d2_idx), .o_valid(vld[2]), .o_wrap(wrp[2]));

    decoder_scan #(.N(2), .DWELL(1)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_mode(mode), .i_load(load), .i_in(din[1:0]),
`ifdef DECODER_SCAN_DIR_EN
        .i_dir(dir),
`endif
        .o_out(d3_out), .o_idx(d3_idx), .o_valid(vld[3]), .o_wrap(wrp[3]));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each instance has a position, the number of edges it has
    // already spent at that position, and whether it was scanning on the last edge.
    int         NN  [4] = '{3, 2, 3, 2};
    int         DWL [4] = '{4, 3, 2, 1};
    int         m_pos   [4] = '{0, 0, 0, 0};
    int         m_held  [4] = '{0, 0, 0, 0};
    bit         m_run   [4] = '{0, 0, 0, 0};
    int         m_idx   [4] = '{0, 0, 0, 0};
    logic [7:0] m_out   [4] = '{0, 0, 0, 0};
    bit         m_valid [4] = '{0, 0, 0, 0};
    bit         m_wrap  [4] = '{0, 0, 0, 0};

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int  m;
            int  v;
            bit  down;
            m    = 1 << NN[k];
            v    = int'(din) % m;
            down = 1'b0;
`ifdef DECODER_SCAN_DIR_EN
            down = dir;
`endif
            if (!rst_n) begin
                m_pos[k] = 0; m_held[k] = 0; m_run[k] = 0;
                m_idx[k] = 0; m_out[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
            end else if (!e) begin
                m_held[k] = 0; m_run[k] = 0;
                m_out[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
            end else if (!mode) begin
                m_run[k] = 0;
                m_idx[k] = v; m_out[k] = 8'(1 << v); m_valid[k] = 1; m_wrap[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (load) begin
                    m_pos[k] = v; m_held[k] = 0;
                end else if (!m_run[k]) begin
                    m_held[k] = 0;
                end else if (m_held[k] + 1 == DWL[k]) begin
                    if (down) begin
                        m_wrap[k] = (m_pos[k] == 0);
                        m_pos[k]  = (m_pos[k] + m - 1) % m;
                    end else begin
                        m_wrap[k] = (m_pos[k] == m - 1);
                        m_pos[k]  = (m_pos[k] + 1) % m;
                    end
                    m_held[k] = 0;
                end else begin
                    m_held[k]++;
                end
                m_run[k] = 1;
                m_idx[k] = m_pos[k]; m_out[k] = 8'(1 << m_pos[k]); m_valid[k] = 1;
            end
        end
    endtask

    function automatic logic [7:0] obs_out(int k);
        case (k)
            0:       return d0_out;
            1:       return {4'h0, d1_out};
            2:       return d2_out;
            default: return {4'h0, d3_out};
        endcase
    endfunction

    function automatic logic [2:0] obs_idx(int k);
        case (k)
            0:       return d0_idx;
            1:       return {1'b0, d1_idx};
            2:       return d2_idx;
            default: return {1'b0, d3_idx};
        endcase
    endfunction

    // One clock: inputs are already stable, the model follows the edge and the
    // outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d_out", k),   32'(obs_out(k)), 32'(m_out[k]));
            chk($sformatf("d%0d_idx", k),   32'(obs_idx(k)), 32'(m_idx[k]));
            chk($sformatf("d%0d_valid", k), 32'(vld[k]),     32'(m_valid[k]));
            chk($sformatf("d%0d_wrap", k),  32'(wrp[k]),     32'(m_wrap[k]));
        end
    endtask

    int scan_tbl [14] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
    int down_tbl [4]  = '{1, 0, 3, 2};

    initial begin
        logic [7:0] exp8;

        // Reset held two cycles, then released with E=0.
        rst_n = 1'b0; e = 1'b0; mode = 1'b0; load = 1'b0; dir = 1'b0; din = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            chk("rst_out",   32'(d0_out), 32'h0);
            chk("rst_idx",   32'(d0_idx), 32'h0);
            chk("rst_valid", 32'(vld[0]), 32'h0);
            chk("rst_wrap",  32'(wrp[0]), 32'h0);
        end

        // Direct sweep on the N=3 instance.
        e = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = 3'(i);
            tick();
            exp8 = 8'h01 << i;
            chk("direct_out",   32'(d0_out), 32'(exp8));
            chk("direct_valid", 32'(vld[0]), 32'h1);
        end

        // Scan with wrap on N=2, DWELL=3; its scan index is still 0 from reset.
        mode = 1'b1; load = 1'b0; dir = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("scan_idx",  32'(d1_idx), 32'(scan_tbl[i]));
            chk("scan_wrap", 32'(wrp[1]), 32'(i == 12));
        end

        // Load on the dwell-expiry cycle of index 2 (N=3, DWELL=4).
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("ld_pre_idx", 32'(d0_idx), 32'h2);
        load = 1'b1; din = 3'd5;
        tick();
        load = 1'b0; din = 3'd0;
        chk("ld_out", 32'(d0_out), 32'h20);
        chk("ld_wrap", 32'(wrp[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_hold", 32'(d0_out), 32'h20);
        end
        tick();
        chk("ld_next", 32'(d0_out), 32'h40);
        chk("ld_next_wrap", 32'(wrp[0]), 32'h0);

        // Pause at index 6 and reset at index 7 (N=3, DWELL=2).
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("pause_pre_idx", 32'(d2_idx), 32'h6);
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_out", 32'(d2_out), 32'h0);
        end
        e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("resume_hold", 32'(d2_out), 32'h40);
        end
        tick();
        chk("resume_next", 32'(d2_out), 32'h80);
        rst_n = 1'b0; tick();
        chk("midrst_out",   32'(d2_out), 32'h0);
        chk("midrst_valid", 32'(vld[2]), 32'h0);
        rst_n = 1'b1; tick();
        chk("rel_idx", 32'(d2_idx), 32'h0);
        chk("rel_out", 32'(d2_out), 32'h01);

`ifdef DECODER_SCAN_DIR_EN
        // Down scan on N=2, DWELL=1, starting from a load of 1.
        dir = 1'b1; load = 1'b1; din = 3'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0;
            chk("down_idx",  32'(d3_idx), 32'(down_tbl[i]));
            chk("down_wrap", 32'(wrp[3]), 32'(i == 2));
        end
        dir = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            e     = ($urandom_range(0, 99) < 90);
            mode  = ($urandom_range(0, 99) < 75);
            load  = ($urandom_range(0, 99) < 10);
            din   = 3'($urandom_range(0, 7));
`ifdef DECODER_SCAN_DIR_EN
            dir   = 1'($urandom_range(0, 1));
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
